muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read operands (rs1/rs2 data) plus the destination index.
- Produces a single write-back (result, rd, write enable) that feeds the register file write port.
- Multi-cycle: asserts busy so the core stalls fetch/decode while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; special-case constants scale with it (all-ones, most-negative).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when unit is IDLE
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a  input  XLEN  rs1 data (multiplicand/dividend)
operand_b  input  XLEN  rs2 data (multiplier/divisor)
rd_in  input  5  destination register index
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
result  output  XLEN  operation result
rd_out  output  5  latched destination index
regwrite_out  output  1  register-file write enable = done && (rd_out != 0)

Behaviour:
- Reset:
  - Synchronous; state=IDLE; busy=0, done=0, result=0, rd_out=0, regwrite_out=0; counter and internal registers cleared.
  - Reset has priority over everything; asserted mid-operation it abandons the op with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE:
  - At edge E0, if start=1: latch funct3, rd_in, operand magnitudes and sign flags; counter=0; go to CALC.
  - If start=0: stay in IDLE.
- CALC:
  - One radix-2 iteration per edge, edges E1..E32.
  - Counter increments each edge; at the edge where counter reaches XLEN-1 the last iteration completes and state goes to DONE.
- DONE:
  - Present during the cycle after E32: done=1; result holds the sign-corrected value; regwrite_out per port rule.
  - Next edge (E33): return to IDLE.
  - Latency is fixed: done is sampled high at E33 for every op, including special cases.
- start is ignored while busy (CALC or DONE), including in the DONE cycle.
- Operand inputs may change freely after E0 without affecting the result.
- result and rd_out hold their last values until the next accepted start; done and regwrite_out are high only in DONE.
- Multiply:
  - Shift-add on unsigned magnitudes into a 2*XLEN product.
  - Negate the product if the effective signs differ.
  - Signedness: MUL/MULH both signed; MULHSU a signed, b unsigned; MULHU both unsigned.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide:
  - Restoring shift-subtract on magnitudes; DIV/REM signed, DIVU/REMU unsigned.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- Special cases (override the datapath result at DONE, same latency):
  - Divisor 0: DIV/DIVU -> all-ones; REM/REMU -> dividend.
  - Signed overflow (most-negative / -1): DIV -> most-negative; REM -> 0.
- rd_in=0: the op executes and done pulses, but regwrite_out stays 0, because the register file does not protect x0.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), rd=5, start at E0 -> busy=1 after E0; done and regwrite_out sampled high only at E33; result=0xFFFFFFEB; rd_out=5; busy=0 after E33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. Each completes at E33.
- rd_in=0, MUL 3*4 -> done pulses with result=12 and regwrite_out=0. During CALC, pulse start with new operands and funct3 -> ignored; result unaffected; exactly one done pulse.
- Start DIVU 1000/3, assert reset before E10 -> after that edge busy=0, done never pulses, result=0. Then a new start MUL 2*3 -> done at E33 relative to its start, result=6.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/write-back bundle between the register file and the RV32M unit.
// The master side issues operations; the slave side is the muldiv datapath.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;
  logic            regwrite_out;

  modport master (
    output start, funct3, operand_a,
    output operand_b, rd_in,
    input  busy, done, result,
    input  rd_out, regwrite_out
  );

  modport slave (
    input  start, funct3, operand_a,
    input  operand_b, rd_in,
    output busy, done, result,
    output rd_out, regwrite_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Fixed latency of one accept edge, XLEN iteration edges and one DONE cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV =
    {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(XLEN-1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] a_q, mag_q;
  logic [XLEN-1:0] acc_q, lo_q;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      rd_q;

  logic            sgn_a, sgn_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] amag, bmag;
  logic [XLEN:0]   mul_sum, r_sh, diff;
  logic [XLEN-1:0] acc_d, lo_d;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo, rem;
  logic            b_zero, ovf;

  // operand signedness per funct3 and magnitude extraction
  always_comb begin
    sgn_a = 1'b1;
    sgn_b = 1'b1;
    unique case (bus.funct3)
      3'b010:  sgn_b = 1'b0;
      3'b011,
      3'b101,
      3'b111: begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
      end
      default: ;
    endcase
    neg_a = sgn_a & bus.operand_a[XLEN-1];
    neg_b = sgn_b & bus.operand_b[XLEN-1];
    amag  = neg_a ? -bus.operand_a
                  : bus.operand_a;
    bmag  = neg_b ? -bus.operand_b
                  : bus.operand_b;
  end

  // one radix-2 step; lo_q holds multiplier or dividend
  always_comb begin
    mul_sum = {1'b0, acc_q} +
              (lo_q[0] ? {1'b0, mag_q}
                       : {(XLEN+1){1'b0}});
    r_sh    = {acc_q, lo_q[XLEN-1]};
    diff    = r_sh - {1'b0, mag_q};
    acc_d   = acc_q;
    lo_d    = lo_q;
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        acc_d = diff[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = r_sh[XLEN-1:0];
        lo_d  = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[XLEN:1];
      lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // sign correction and special cases, evaluated on the last step
  always_comb begin
    prod   = {acc_d, lo_d};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    quo    = (sa_q ^ sb_q) ? -lo_d : lo_d;
    rem    = sa_q ? -acc_d : acc_d;
    b_zero = (mag_q == '0);
    ovf    = !op_q[0] && (a_q == MINV) &&
             sb_q && (mag_q == XLEN'(1));
    res_d  = '0;
    unique case (op_q)
      3'b000: res_d = prod_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011: res_d = prod_s[2*XLEN-1:XLEN];
      3'b100,
      3'b101: begin
        if (b_zero)   res_d = ONES;
        else if (ovf) res_d = MINV;
        else          res_d = quo;
      end
      3'b110,
      3'b111: begin
        if (b_zero)   res_d = a_q;
        else if (ovf) res_d = '0;
        else          res_d = rem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: if (cnt_q == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = (state_q != IDLE);
    bus.done         = (state_q == DONE);
    bus.regwrite_out = (state_q == DONE) &&
                       (rd_q != 5'd0);
    bus.result       = res_q;
    bus.rd_out       = rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      a_q   <= '0;
      mag_q <= '0;
      acc_q <= '0;
      lo_q  <= '0;
      res_q <= '0;
      rd_q  <= '0;
    end else begin
      if (state_q == IDLE && bus.start) begin
        cnt_q <= '0;
        op_q  <= bus.funct3;
        sa_q  <= neg_a;
        sb_q  <= neg_b;
        a_q   <= bus.operand_a;
        rd_q  <= bus.rd_in;
        acc_q <= '0;
        if (bus.funct3[2]) begin
          lo_q  <= amag;
          mag_q <= bmag;
        end else begin
          lo_q  <= bmag;
          mag_q <= amag;
        end
      end
      if (state_q == CALC) begin
        acc_q <= acc_d;
        lo_q  <= lo_d;
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == LAST) res_q <= res_d;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Expected results are hand-computed RV32M values.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ndone  = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(
    .XLEN (32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.done === 1'b1) ndone++;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
  endtask

  task automatic do_op(
    input string       tag,
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  rd,
    input logic [31:0] exp,
    input bit          noise
  );
    int lat;
    int nd0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = f;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.rd_in     = rd;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.rd_in     = 5'(($urandom));
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    nd0 = ndone;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (noise && i == 5) begin
        bus.start     = 1'b1;
        bus.funct3    = 3'b101;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
      end
    end
    chk({tag, ".lat"}, 32'(lat), 32'd32);
    chk({tag, ".res"}, bus.result, exp);
    chk({tag, ".rd"}, 32'(bus.rd_out), 32'(rd));
    chk({tag, ".rw"}, 32'(bus.regwrite_out),
        32'(rd != 5'd0));
    if (noise) bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    chk({tag, ".dn0"}, 32'(bus.done), 32'd0);
    chk({tag, ".hold"}, bus.result, exp);
    if (noise) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".nobusy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".ndone"}, 32'(ndone - nd0), 32'd1);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.funct3    = 3'b000;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.rd_in     = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.res", bus.result, 32'd0);
    chk("rst.rd", 32'(bus.rd_out), 32'd0);
    chk("rst.rw", 32'(bus.regwrite_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD,
          5'd5, 32'hFFFFFFEB, 1'b0);
    do_op("mulh", 3'b001, 32'h80000000,
          32'h80000000, 5'd1, 32'h40000000, 1'b0);
    do_op("mulhu", 3'b011, 32'hFFFFFFFF,
          32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b0);
    do_op("mulhsu", 3'b010, 32'hFFFFFFFF,
          32'hFFFFFFFF, 5'd3, 32'hFFFFFFFF, 1'b0);
    do_op("div", 3'b100, 32'hFFFFFFF9, 32'd2,
          5'd4, 32'hFFFFFFFD, 1'b0);
    do_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2,
          5'd6, 32'hFFFFFFFF, 1'b0);
    do_op("divu", 3'b101, 32'd100, 32'd7,
          5'd7, 32'd14, 1'b0);
    do_op("remu", 3'b111, 32'd100, 32'd7,
          5'd8, 32'd2, 1'b0);
    do_op("div0", 3'b100, 32'd5, 32'd0,
          5'd9, 32'hFFFFFFFF, 1'b0);
    do_op("remu0", 3'b111, 32'd5, 32'd0,
          5'd10, 32'd5, 1'b0);
    do_op("divov", 3'b100, 32'h80000000,
          32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b0);
    do_op("remov", 3'b110, 32'h80000000,
          32'hFFFFFFFF, 5'd12, 32'd0, 1'b0);
    do_op("mulx0", 3'b000, 32'd3, 32'd4,
          5'd0, 32'd12, 1'b1);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.funct3    = 3'b101;
    bus.operand_a = 32'd1000;
    bus.operand_b = 32'd3;
    bus.rd_in     = 5'd13;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.res", bus.result, 32'd0);
    chk("abort.rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int nd0;
      nd0 = ndone;
      repeat (40) @(negedge clk);
      chk("abort.nodone", 32'(ndone - nd0), 32'd0);
      chk("abort.hold", bus.result, 32'd0);
    end
    do_op("mul23", 3'b000, 32'd2, 32'd3,
          5'd14, 32'd6, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
